// File: rtl/sar_adc_seq.sv
// sar_adc_seq: multi-channel SAR ADC sequencer with
// per-channel averaging and continuous scan mode.
module sar_adc_seq #(
    parameter int ADC_WIDTH = 8,
    parameter int CH_NUM    = 4,
    parameter int AVG_LOG2  = 0,
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cont,
    input  logic [CH_NUM-1:0]    ch_mask,
    input  logic                 cmp,
    output logic [ADC_WIDTH-1:0] DACF,
    output logic [CW-1:0]        ch_sel,
    output logic                 smp,
    output logic                 busy,
    output logic                 den,
    output logic                 eoc,
    output logic [ADC_WIDTH-1:0] Dout,
    output logic [CW-1:0]        Dch
);

    localparam int BW = $clog2(ADC_WIDTH);
    localparam int AW = ADC_WIDTH + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] AVG_LAST = NW'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] CONV   = 2'd2;
    localparam logic [1:0] OUT    = 2'd3;

    logic [1:0]           state;
    logic [ADC_WIDTH-1:0] sar;
    logic [ADC_WIDTH-1:0] trial;
    logic [ADC_WIDTH-1:0] sar_nxt;
    logic [BW-1:0]        bit_idx;
    logic [AW-1:0]        acc;
    logic [AW-1:0]        acc_sum;
    logic [NW-1:0]        avg_cnt;
    logic [CH_NUM-1:0]    mask_q;
    logic [CW-1:0]        first_ch;
    logic [CW-1:0]        next_ch;
    logic                 has_next;
    logic                 any_req;

    assign trial   = sar | (ADC_WIDTH'(1) << bit_idx);
    assign sar_nxt = cmp ? trial : sar;
    assign acc_sum = acc + AW'(sar_nxt);
    assign any_req = |ch_mask;

    // lowest enabled channel of the live mask, used at scan start
    always_comb begin
        first_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_ch = CW'(i);
        end
    end

    always_comb begin
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_sel))) begin
                next_ch  = CW'(i);
                has_next = 1'b1;
            end
        end
    end

    assign DACF = (state == CONV) ? trial : '0;
    assign smp  = (state == SAMPLE);
    assign busy = (state != IDLE);
    assign den  = (state == OUT);
    assign eoc  = den && !has_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sar     <= '0;
            bit_idx <= '0;
            acc     <= '0;
            avg_cnt <= '0;
            mask_q  <= '0;
            ch_sel  <= '0;
            Dout    <= '0;
            Dch     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && any_req) begin
                        mask_q  <= ch_mask;
                        ch_sel  <= first_ch;
                        acc     <= '0;
                        avg_cnt <= '0;
                        state   <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    sar     <= '0;
                    bit_idx <= BW'(ADC_WIDTH - 1);
                    state   <= CONV;
                end
                CONV: begin
                    sar <= sar_nxt;
                    if (bit_idx == '0) begin
                        acc <= acc_sum;
                        if (avg_cnt == AVG_LAST) begin
                            Dout  <= acc_sum[AVG_LOG2 +: ADC_WIDTH];
                            Dch   <= ch_sel;
                            state <= OUT;
                        end else begin
                            avg_cnt <= avg_cnt + NW'(1);
                            state   <= SAMPLE;
                        end
                    end else begin
                        bit_idx <= bit_idx - BW'(1);
                    end
                end
                OUT: begin
                    acc     <= '0;
                    avg_cnt <= '0;
                    if (has_next) begin
                        ch_sel <= next_ch;
                        state  <= SAMPLE;
                    end else if (cont && any_req) begin
                        mask_q <= ch_mask;
                        ch_sel <= first_ch;
                        state  <= SAMPLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq: drives two sequencers (no averaging and 4x averaging)
// with an ideal comparator and checks results against an arithmetic model.
module tb_sar_adc_seq;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] ch_mask = 4'h0;

    logic       cmp  [2];
    logic [7:0] dacf [2];
    logic [7:0] dout [2];
    logic [1:0] chs  [2];
    logic [1:0] dch  [2];
    logic       smp  [2];
    logic       busy [2];
    logic       den  [2];
    logic       eoc  [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // analog inputs are held doubled so half-LSB levels stay integral
    int vmode = 0;
    int fixv [4];
    int rv   [4][4];

    int k  [2];
    int kb [2];
    int n  [2];
    int nb [2];
    int st [2];
    bit inch [2];

    logic [7:0] r_dout [2][256];
    logic [1:0] r_dch  [2][256];
    bit         r_eoc  [2][256];
    int         r_lat  [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_adc_seq #(.ADC_WIDTH(8), .CH_NUM(4), .AVG_LOG2(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .ch_mask(ch_mask), .cmp(cmp[0]), .DACF(dacf[0]),
        .ch_sel(chs[0]), .smp(smp[0]), .busy(busy[0]), .den(den[0]),
        .eoc(eoc[0]), .Dout(dout[0]), .Dch(dch[0])
    );

    sar_adc_seq #(.ADC_WIDTH(8), .CH_NUM(4), .AVG_LOG2(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .ch_mask(ch_mask), .cmp(cmp[1]), .DACF(dacf[1]),
        .ch_sel(chs[1]), .smp(smp[1]), .busy(busy[1]), .den(den[1]),
        .eoc(eoc[1]), .Dout(dout[1]), .Dch(dch[1])
    );

    function automatic int vin2(int ch, int rel);
        if (vmode == 0) return fixv[ch];
        return rv[ch][rel & 3];
    endfunction

    // ideal SAR result is floor(vin) saturated, averaged by plain division
    function automatic int exp_dout(int a, int ch, int m);
        int s = 0;
        int v;
        for (int j = 0; j < (1 << a); j++) begin
            v = vin2(ch, m * (1 << a) + j) / 2;
            if (v > 255) v = 255;
            s += v;
        end
        return s >> a;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int j;
            if (!rst_n) inch[i] = 1'b0;
            if (smp[i] === 1'b1) begin
                k[i]++;
                if (!inch[i]) begin
                    st[i] = cyc;
                    inch[i] = 1'b1;
                end
            end
            if (den[i] === 1'b1) begin
                j = n[i] % 256;
                r_dout[i][j] = dout[i];
                r_dch[i][j]  = dch[i];
                r_eoc[i][j]  = eoc[i];
                r_lat[i][j]  = cyc - st[i] + 1;
                n[i]++;
                inch[i] = 1'b0;
            end
            cmp[i] = (2 * int'(dacf[i]) <= vin2(int'(chs[i]), k[i] - 1 - kb[i]));
        end
    end

    task automatic mark;
        for (int i = 0; i < 2; i++) begin
            kb[i] = k[i];
            nb[i] = n[i];
        end
    endtask

    task automatic do_scan(input logic [3:0] m, output bit to);
        ch_mask = m;
        mark();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (!busy[0] && !busy[1]) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        start = 1'b1;
        cont = 1'b1;
        ch_mask = 4'hF;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({dacf[i], chs[i], smp[i], busy[i], den[i], eoc[i], dout[i], dch[i]} !== '0) begin
                bad++;
                $display("FAIL reset u%0d: got dacf=%h ch=%0d smp=%b busy=%b den=%b eoc=%b dout=%h dch=%0d want all 0",
                         i, dacf[i], chs[i], smp[i], busy[i], den[i], eoc[i], dout[i], dch[i]);
            end
        end
        start = 1'b0;
        cont = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b%b want 00", busy[0], busy[1]);
        end
        ch_mask = 4'h1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        total++;
        if (smp[0] !== 1'b1 || smp[1] !== 1'b1) begin
            bad++;
            $display("FAIL first_sample: got smp=%b%b want 11", smp[0], smp[1]);
        end
        for (int c = 0; c < 100 && (busy[0] || busy[1]); c++) @(negedge clk);
    endtask

    task automatic test_dacf_sequence;
        logic [7:0] seq [8];
        int got;
        seq = '{8'h80, 8'h40, 8'h60, 8'h70, 8'h78, 8'h7C, 8'h7E, 8'h7F};
        vmode = 0;
        for (int c = 0; c < 4; c++) fixv[c] = 255;
        ch_mask = 4'h1;
        mark();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 5 && smp[0] !== 1'b1; c++) @(negedge clk);
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            total++;
            if (dacf[0] !== seq[s]) begin
                bad++;
                $display("FAIL dacf_step%0d: got %h want %h", s, dacf[0], seq[s]);
            end
        end
        for (int c = 0; c < 100 && (busy[0] || busy[1]); c++) @(negedge clk);
        got = n[0] - nb[0];
        total++;
        if (got != 1 || r_dout[0][nb[0] % 256] !== 8'h7F || r_eoc[0][nb[0] % 256] !== 1'b1
            || r_dch[0][nb[0] % 256] !== 2'd0 || r_lat[0][nb[0] % 256] != 10) begin
            bad++;
            $display("FAIL single_conv: got n=%0d dout=%h eoc=%b dch=%0d lat=%0d want 1 7f 1 0 10",
                     got, r_dout[0][nb[0] % 256], r_eoc[0][nb[0] % 256],
                     r_dch[0][nb[0] % 256], r_lat[0][nb[0] % 256]);
        end
    endtask

    task automatic test_scans;
        logic [3:0] msk;
        bit to;
        for (int sc = 0; sc < 8; sc++) begin
            if (sc == 0) begin
                vmode = 0;
                fixv = '{'h40, 'h80, 'hC0, 'h140};
                msk = 4'b1010;
            end else if (sc == 1) begin
                vmode = 1;
                rv[0] = '{'h20, 'h26, 'h20, 'h26};
                msk = 4'b0001;
            end else begin
                vmode = 1;
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++) rv[c][j] = $urandom_range(0, 511);
                msk = 4'($urandom_range(1, 15));
            end
            do_scan(msk, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL scan%0d timeout: got busy=%b%b want 00", sc, busy[0], busy[1]);
            end
            for (int i = 0; i < 2; i++) begin
                int a, m, idx, cnt, got, e_dout, e_lat;
                bit e_eoc;
                a = (i == 0) ? 0 : 2;
                cnt = $countones(msk);
                got = n[i] - nb[i];
                total++;
                if (got != cnt) begin
                    bad++;
                    $display("FAIL scan%0d u%0d den_count: got %0d want %0d", sc, i, got, cnt);
                end
                m = 0;
                for (int ch = 0; ch < 4; ch++) begin
                    if (msk[ch]) begin
                        if (m < got) begin
                            idx = (nb[i] + m) % 256;
                            e_dout = exp_dout(a, ch, m);
                            e_eoc = (m == cnt - 1);
                            e_lat = (1 + W) * (1 << a) + 1;
                            total++;
                            if (r_dch[i][idx] !== 2'(ch) || r_dout[i][idx] !== 8'(e_dout)
                                || r_eoc[i][idx] !== e_eoc || r_lat[i][idx] != e_lat) begin
                                bad++;
                                $display("FAIL scan%0d u%0d ch%0d: got dch=%0d dout=%h eoc=%b lat=%0d want dch=%0d dout=%h eoc=%b lat=%0d",
                                         sc, i, ch, r_dch[i][idx], r_dout[i][idx], r_eoc[i][idx],
                                         r_lat[i][idx], ch, e_dout, e_eoc, e_lat);
                            end
                        end
                        m++;
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int d0 = 0;
        int d2 = 0;
        bit prev = 1'b0;
        vmode = 0;
        for (int c = 0; c < 4; c++) fixv[c] = 'h100;
        ch_mask = 4'h1;
        cont = 1'b1;
        mark();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (prev && cont) begin
                total++;
                if (smp[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL cont_restart: got smp=%b want 1", smp[0]);
                end
            end
            prev = den[0];
            if (den[0]) d0++;
            if (den[1]) d2++;
            if (cont && d0 == 3 && smp[0]) begin
                cont = 1'b0;
                ch_mask = 4'hF;
            end
            if (!cont && !busy[0] && !busy[1]) break;
            @(negedge clk);
        end
        total++;
        if (d0 != 4 || d2 != 1 || busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL cont_stop: got dens=%0d/%0d busy=%b%b want 4/1 00", d0, d2, busy[0], busy[1]);
        end
        for (int i = 0; i < 2; i++) begin
            int idx;
            idx = (n[i] - 1) % 256;
            total++;
            if (r_eoc[i][idx] !== 1'b1 || r_dch[i][idx] !== 2'd0 || r_dout[i][idx] !== 8'h80) begin
                bad++;
                $display("FAIL cont_last u%0d: got eoc=%b dch=%0d dout=%h want 1 0 80",
                         i, r_eoc[i][idx], r_dch[i][idx], r_dout[i][idx]);
            end
        end
    endtask

    task automatic test_reset_midconv;
        bit to;
        vmode = 0;
        for (int c = 0; c < 4; c++) fixv[c] = 'h186;
        ch_mask = 4'h1;
        mark();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 5 && smp[0] !== 1'b1; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({dacf[i], chs[i], smp[i], busy[i], den[i], eoc[i], dout[i], dch[i]} !== '0) begin
                bad++;
                $display("FAIL async_reset u%0d: got dacf=%h busy=%b dout=%h want 0",
                         i, dacf[i], busy[i], dout[i]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (n[0] != nb[0] || n[1] != nb[1] || busy[0] || busy[1]) begin
            bad++;
            $display("FAIL abort_no_den: got dens=%0d/%0d want 0/0", n[0] - nb[0], n[1] - nb[1]);
        end
        for (int c = 0; c < 4; c++) fixv[c] = 'hA6;
        do_scan(4'h1, to);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (to || n[i] - nb[i] != 1 || r_dout[i][nb[i] % 256] !== 8'h53) begin
                bad++;
                $display("FAIL after_abort u%0d: got n=%0d dout=%h want 1 53",
                         i, n[i] - nb[i], r_dout[i][nb[i] % 256]);
            end
        end
    endtask

    task automatic test_ignore;
        bit seen = 1'b0;
        ch_mask = 4'h0;
        mark();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (busy[0] || busy[1] || den[0] || den[1] || eoc[0] || eoc[1]) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen || dout[0] !== 8'(exp_dout(0, 0, 0))) begin
            bad++;
            $display("FAIL empty_mask: got activity=%b dout=%h want 0 %h",
                     seen, dout[0], exp_dout(0, 0, 0));
        end
        for (int c = 0; c < 4; c++) fixv[c] = 'h100;
        ch_mask = 4'h1;
        mark();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 200 && (busy[0] || busy[1]); c++) begin
            start = busy[0] && busy[1] && (c % 3 == 1);
            @(negedge clk);
        end
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (busy[0] || busy[1]) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen || n[0] - nb[0] != 1 || n[1] - nb[1] != 1) begin
            bad++;
            $display("FAIL busy_start: got restart=%b dens=%0d/%0d want 0 1/1",
                     seen, n[0] - nb[0], n[1] - nb[1]);
        end
    endtask

    initial begin
        test_reset();
        test_dacf_sequence();
        test_scans();
        test_back_to_back();
        test_reset_midconv();
        test_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
